// File: rtl/rv32m_divider.sv
// rv32m_divider: multi-cycle RV32M DIV/DIVU/REM/REMU unit (restoring shift-subtract).
//
// Ports:
//   i_clk     - clock, all state updates on rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_valid   - start request, accepted only while o_ready is high and i_flush is low
//   i_op      - 0 DIV, 1 DIVU, 2 REM, 3 REMU (latched on accept)
//   i_a       - dividend (rs1), latched on accept
//   i_b       - divisor (rs2), latched on accept
//   i_flush   - abort any operation in progress; never accepts a request on the same edge
//   o_ready   - high in IDLE only
//   o_done    - one-cycle pulse, o_result valid
//   o_result  - quotient or remainder, held until the next completion
//
// Timing: accept at edge T, 32 iterations on edges T+1..T+32, sign fix-up and result load
// at T+33. Divide-by-zero and signed overflow skip CALC and finish at T+1.

module rv32m_divider (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_flush,
    output logic        o_ready,
    output logic        o_done,
    output logic [31:0] o_result
);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quot_q, quot_d;     // dividend bits shift out, quotient bits shift in
    logic [31:0] rem_q, rem_d;       // partial remainder
    logic [31:0] dvs_q, dvs_d;       // divisor magnitude
    logic        is_rem_q, is_rem_d;
    logic        neg_q, neg_d;       // negate the selected value in FIX
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    logic        signed_op;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, sgn_ovf;
    logic [32:0] rem_sh, diff;
    logic [31:0] fix_val, fix_res;

    always_comb begin
        signed_op = ~i_op[0];
        a_neg     = signed_op & i_a[31];
        b_neg     = signed_op & i_b[31];
        a_mag     = a_neg ? (32'd0 - i_a) : i_a;
        b_mag     = b_neg ? (32'd0 - i_b) : i_b;
        div_zero  = (i_b == 32'd0);
        sgn_ovf   = signed_op && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

        // Bit 32 of diff is the borrow: set means the trial subtraction failed.
        rem_sh    = {rem_q, quot_q[31]};
        diff      = rem_sh - {1'b0, dvs_q};

        fix_val   = is_rem_q ? rem_q : quot_q;
        fix_res   = neg_q ? (32'd0 - fix_val) : fix_val;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        is_rem_d = is_rem_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (i_flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        is_rem_d = i_op[1];
                        cnt_d    = 5'd0;
                        dvs_d    = b_mag;
                        // Special cases preload the final value with no sign fix-up so FIX
                        // passes it straight through one edge later.
                        if (div_zero) begin
                            quot_d  = 32'hFFFF_FFFF;
                            rem_d   = i_a;
                            neg_d   = 1'b0;
                            state_d = StFix;
                        end else if (sgn_ovf) begin
                            quot_d  = 32'h8000_0000;
                            rem_d   = 32'd0;
                            neg_d   = 1'b0;
                            state_d = StFix;
                        end else begin
                            quot_d  = a_mag;
                            rem_d   = 32'd0;
                            neg_d   = i_op[1] ? a_neg : (a_neg ^ b_neg);
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (diff[32]) begin
                        rem_d  = rem_sh[31:0];
                        quot_d = {quot_q[30:0], 1'b0};
                    end else begin
                        rem_d  = diff[31:0];
                        quot_d = {quot_q[30:0], 1'b1};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    result_d = fix_res;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            quot_q   <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            is_rem_q <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            is_rem_q <= is_rem_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign o_ready  = (state_q == StIdle);
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_rv32m_divider.sv
// Self-checking bench for rv32m_divider: directed corner cases plus randomized operations
// compared against an arithmetic reference of the RISC-V M-extension divide rules.

module tb_rv32m_divider;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [1:0]  i_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        i_flush;
    logic        o_ready;
    logic        o_done;
    logic [31:0] o_result;

    int n_tests = 0;
    int n_fail  = 0;

    rv32m_divider u_dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_flush  (i_flush),
        .o_ready  (o_ready),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            2'd1: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            2'd2: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issues one request (o_ready must be high) and waits for o_done; returns in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise);
        int          lat;
        bit          moved;
        logic [31:0] prev;
        lat   = 0;
        moved = 0;
        prev  = o_result;
        i_valid = 1'b1;
        i_op    = op;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_op    = 2'($urandom);
        i_a     = $urandom;
        i_b     = $urandom;
        check_eq({tag, " done_low_after_accept"}, {31'd0, o_done}, 32'd0);
        for (int i = 1; i <= 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_done) begin
                lat = i;
                break;
            end
            if (o_result !== prev) moved = 1;
            if (noise) begin
                i_valid = 1'($urandom);
                i_op    = 2'($urandom);
                i_a     = $urandom;
                i_b     = $urandom;
            end
        end
        i_valid = 1'b0;
        check_eq({tag, " latency"}, lat, ref_latency(op, a, b));
        check_eq({tag, " result"}, o_result, ref_result(op, a, b));
        check_eq({tag, " result_held"}, {31'd0, moved}, 32'd0);
        check_eq({tag, " ready_in_done"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        bit          seen;
        logic [1:0]  op;
        logic [31:0] a, b;

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_op    = 2'd0;
        i_a     = 32'd0;
        i_b     = 32'd0;
        i_flush = 1'b0;
        #1;
        check_eq("rst ready", {31'd0, o_ready}, 32'd1);
        check_eq("rst done", {31'd0, o_done}, 32'd0);
        check_eq("rst result", o_result, 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Directed corner cases, issued back to back from the done cycle.
        run_op("div 100/7", 2'd0, 32'd100, 32'd7, 0);
        run_op("rem 100/7", 2'd2, 32'd100, 32'd7, 0);
        run_op("rem -100/7", 2'd2, 32'hFFFF_FF9C, 32'd7, 0);
        run_op("div -100/7", 2'd0, 32'hFFFF_FF9C, 32'd7, 1);
        run_op("divu ff/2", 2'd1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op("divu 5/0", 2'd1, 32'd5, 32'd0, 0);
        run_op("remu 5/0", 2'd3, 32'd5, 32'd0, 0);
        run_op("div ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("divu ovf pattern", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("rem 7/-3", 2'd2, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("div -7/-3", 2'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFD, 0);

        // Flush mid-CALC together with a new request: neither may complete.
        held = o_result;
        run_op("pre-flush rem", 2'd2, 32'd99, 32'd10, 0);
        held = o_result;
        i_valid = 1'b1;
        i_op    = 2'd0;
        i_a     = 32'd100;
        i_b     = 32'd7;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_op    = 2'd1;
        i_a     = 32'd50;
        i_b     = 32'd3;
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        check_eq("flush ready", {31'd0, o_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge i_clk);
            #1;
            if (o_done) seen = 1;
        end
        check_eq("flush no_done", {31'd0, seen}, 32'd0);
        check_eq("flush result_held", o_result, held);

        // Back-to-back issue from the done cycle, then asynchronous reset mid-CALC.
        run_op("pre-reset div", 2'd0, 32'd1000, 32'd3, 0);
        i_valid = 1'b1;
        i_op    = 2'd1;
        i_a     = 32'd12345;
        i_b     = 32'd11;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        check_eq("b2b accepted", {31'd0, o_ready}, 32'd0);
        repeat (4) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_eq("async rst result", o_result, 32'd0);
        check_eq("async rst done", {31'd0, o_done}, 32'd0);
        check_eq("async rst ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        run_op("post-reset divu", 2'd1, 32'd12345, 32'd11, 0);

        // Randomized operations against the reference.
        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                2: begin
                    a = 32'($signed($urandom_range(0, 400)) - 200);
                    b = 32'($signed($urandom_range(0, 40)) - 20);
                end
                3: b = $urandom_range(1, 16);
                default: ;
            endcase
            run_op("random", op, a, b, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
